sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 110 +++++++++++
 tb/tb_sw_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer: two-flop synchronizer, shared sample-tick prescaler,
// per-bit stability counters and a short start-up sequence that preloads the outputs.
module sw_debounce #(
  parameter int NUM_BITS     = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] SW,
  output logic [NUM_BITS-1:0] SW_pressed,
  output logic                ready,
  output logic                busy
);

  // state | meaning
  // INIT0 | after reset, synchronizer filling (held two cycles)
  // INIT1 | sync2 carries the real switch level; load outputs on exit
  // RUN   | normal debounce operation until reset

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    INIT0 = 2'd0,
    INIT1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                prime_q;
  logic                load_init;
  logic [NUM_BITS-1:0] sync1_q, sync2_q;
  logic [NUM_BITS-1:0] pressed_q, pressed_d;
  logic                ready_q, ready_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;
  logic [CW-1:0]       cnt_q [NUM_BITS];
  logic [CW-1:0]       cnt_d [NUM_BITS];

  assign tick    = (presc_q == PRESC_MAX);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // INIT0 waits for prime_q so the INIT1->RUN load sees a fully synchronized level.
  always_comb begin
    state_d   = state_q;
    load_init = 1'b0;
    ready_d   = ready_q;
    case (state_q)
      INIT0: if (prime_q) state_d = INIT1;
      INIT1: begin
        state_d   = RUN;
        load_init = 1'b1;
        ready_d   = 1'b1;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT0;
    endcase
  end

  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < NUM_BITS; i++) cnt_d[i] = cnt_q[i];
    if (load_init) begin
      pressed_d = sync2_q;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NUM_BITS; i++) begin
        if (sync2_q[i] == pressed_q[i]) begin
          cnt_d[i] = '0;
        end else if (tick) begin
          if (cnt_q[i] == CNT_MAX) begin
            pressed_d[i] = sync2_q[i];
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT0;
      prime_q   <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      pressed_q <= '0;
      ready_q   <= 1'b0;
      presc_q   <= '0;
      for (int i = 0; i < NUM_BITS; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      prime_q   <= 1'b1;
      sync1_q   <= SW;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      ready_q   <= ready_d;
      presc_q   <= presc_d;
      for (int i = 0; i < NUM_BITS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign SW_pressed = pressed_q;
  assign ready      = ready_q;
  assign busy       = (state_q == RUN) && (|(sync2_q ^ pressed_q));

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: two instances (4/4/3 and minimum 2/2) driven by shared
// stimulus, compared every cycle against a tick-arithmetic reference model.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] pa, pb;
  logic       ra, rb, ba, bb;

  always #5 clk = ~clk;

  sw_debounce #(.NUM_BITS(4), .TICK_DIV(4), .STABLE_TICKS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .SW(sw), .SW_pressed(pa), .ready(ra), .busy(ba)
  );

  sw_debounce #(.NUM_BITS(4), .TICK_DIV(2), .STABLE_TICKS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .SW(sw), .SW_pressed(pb), .ready(rb), .busy(bb)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Reference model: a change is accepted once the number of tick edges seen
  // since the synchronized mismatch began reaches STABLE_TICKS.
  function automatic int div_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction
  function automatic int stab_of(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  bit         m_valid = 1'b0;
  int         m_e;
  logic [3:0] m_s1, m_s2;
  logic [3:0] m_pressed [2];
  bit         m_ready [2];
  int         m_start [2][4];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1;
      m_e     = 0;
      m_s1    = '0;
      m_s2    = '0;
      for (int k = 0; k < 2; k++) begin
        m_pressed[k] = '0;
        m_ready[k]   = 1'b0;
        for (int i = 0; i < 4; i++) m_start[k][i] = -1;
      end
    end else if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        if (m_e == 2) begin
          m_pressed[k] = m_s2;
          m_ready[k]   = 1'b1;
        end else if (m_ready[k]) begin
          for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_pressed[k][i]) begin
              m_start[k][i] = -1;
            end else begin
              if (m_start[k][i] < 0) m_start[k][i] = m_e;
              if ((m_e + 1) / div_of(k) - m_start[k][i] / div_of(k) == stab_of(k)) begin
                m_pressed[k][i] = m_s2[i];
                m_start[k][i]   = -1;
              end
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
      m_e++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("a.pressed", 32'(pa), 32'(m_pressed[0]));
      chk("a.ready",   32'(ra), 32'(m_ready[0]));
      chk("a.busy",    32'(ba), 32'(m_ready[0] && (|(m_s2 ^ m_pressed[0]))));
      chk("a.presc",   32'(dut_a.presc_q), 32'(m_e % 4));
      chk("b.pressed", 32'(pb), 32'(m_pressed[1]));
      chk("b.ready",   32'(rb), 32'(m_ready[1]));
      chk("b.busy",    32'(bb), 32'(m_ready[1] && (|(m_s2 ^ m_pressed[1]))));
      chk("b.presc",   32'(dut_b.presc_q), 32'(m_e % 2));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int         edges, lat, busy_cnt, t32, t2, t3, t0, cyc;
  logic [3:0] pa_prev;

  initial begin
    rst_n = 1'b0;
    sw    = 4'b1010;
    step(3);
    rst_n = 1'b1;

    // start-up load
    edges = 0;
    while (!ra && edges < 10) begin
      step(1);
      edges++;
    end
    chk("init_edges", 32'(edges), 32'd3);
    chk("init_load",  32'(pa), 32'b1010);
    chk("init_busy",  32'(ba), 32'd0);
    step(5);

    // clean change on bit 0
    sw[0]    = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    while (pa[0] == 1'b0 && lat < 30) begin
      step(1);
      lat++;
      if (pa[0] == 1'b0 && ba) busy_cnt++;
    end
    chk("clean_lat_range", 32'(lat >= 11 && lat <= 14), 32'd1);
    chk("clean_value",     32'(pa), 32'b1011);
    chk("clean_busy_len",  32'(busy_cnt), 32'(lat - 2));
    chk("clean_busy_done", 32'(ba), 32'd0);
    step(3);

    // bounce rejection on bit 1
    cyc = 0;
    while (cyc < 40) begin
      sw[1] = 1'b0;
      step(5);
      sw[1] = 1'b1;
      lat   = $urandom_range(1, 4);
      step(lat);
      cyc += 5 + lat;
    end
    step(4);
    chk("bounce_hold", 32'(pa[1]), 32'd1);
    step(4);

    // simultaneous bits 3/2, bit 0 four cycles later
    sw[3:2] = ~sw[3:2];
    step(4);
    sw[0] = ~sw[0];
    t3 = -1; t2 = -1; t0 = -1;
    pa_prev = pa;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (t3 < 0 && pa[3] != pa_prev[3]) t3 = c;
      if (t2 < 0 && pa[2] != pa_prev[2]) t2 = c;
      if (t0 < 0 && pa[0] != pa_prev[0]) t0 = c;
      pa_prev = pa;
    end
    t32 = t3 - t2;
    chk("simul_same_edge", 32'(t32), 32'd0);
    chk("simul_gap",       32'(t0 - t3), 32'd4);
    chk("simul_value",     32'(pa), 32'(sw));

    // reset while a change is pending
    sw[1] = ~sw[1];
    edges = 0;
    while (!ba && edges < 10) begin
      step(1);
      edges++;
    end
    chk("rst_busy_seen", 32'(ba), 32'd1);
    step(2);
    rst_n = 1'b0;
    step(1);
    chk("rst_pressed_clr", 32'(pa), 32'd0);
    chk("rst_ready_clr",   32'(ra), 32'd0);
    rst_n = 1'b1;
    step(3);
    chk("rst_reload_ready", 32'(ra), 32'd1);
    chk("rst_reload_value", 32'(pa), 32'(sw));
    step(6);

    // minimum-parameter instance latency
    sw[0] = ~sw[0];
    lat   = 0;
    while (pb[0] != sw[0] && lat < 20) begin
      step(1);
      lat++;
    end
    chk("min_lat", 32'(lat >= 5 && lat <= 6), 32'd1);
    step(4);

    // random levels with random hold times
    for (int r = 0; r < 40; r++) begin
      sw = 4'($urandom);
      step($urandom_range(1, 20));
    end
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
